mem_sram_ctrl: RTL and testbench

//  Responder side of the MEM-stage data-memory interface: accepts one 32-bit load/store from MEM_Stage,

---
 rtl/sram_pkg.sv | 21 ++
 rtl/sram_rd_buffer.sv | 38 +++
 rtl/mem_sram_ctrl.sv | 142 ++++++++++++++
 tb/tb_mem_sram_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared state encoding, defaults and address helper for the SRAM controller
package sram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;
    localparam int          SRAM_DW           = 16;

    // 32-bit word index of a byte address relative to the SRAM window base
    function automatic logic [29:0] word_index(input logic [31:0] addr, input logic [31:0] base);
        logic [31:0] off;
        off = addr - base;
        return off[31:2];
    endfunction

endpackage

// File: rtl/sram_rd_buffer.sv
// rtl/sram_rd_buffer.sv - one-entry read buffer {valid, word, data}, used when MEM_SRAM_RDBUF_EN is defined
module sram_rd_buffer #(
    parameter int WAW = 17
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           fill,
    input  logic [WAW-1:0] fill_word,
    input  logic [31:0]    fill_data,
    input  logic           inval,
    input  logic [WAW-1:0] inval_word,
    input  logic [WAW-1:0] look_word,
    output logic           hit,
    output logic [31:0]    hit_data
);

    logic           valid;
    logic [WAW-1:0] word;
    logic [31:0]    data;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            word  <= '0;
            data  <= '0;
        end else if (fill) begin
            valid <= 1'b1;
            word  <= fill_word;
            data  <= fill_data;
        end else if (inval && inval_word == word) begin
            valid <= 1'b0;
        end
    end

    assign hit      = valid && (look_word == word);
    assign hit_data = data;

endmodule

// File: rtl/mem_sram_ctrl.sv
// rtl/mem_sram_ctrl.sv - 32-bit MEM-stage load/store as two 16-bit SRAM accesses with pipeline freeze
// Optional read buffer enabled by defining MEM_SRAM_RDBUF_EN.
module mem_sram_ctrl
    import sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
    parameter int          SRAM_AW     = 18,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        addr,
    input  logic [31:0]        wr_data,
    output logic [31:0]        rd_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_we_n
);

    localparam int         WAW      = SRAM_AW - 1;
    localparam logic [3:0] LAST     = 4'(WAIT_CYCLES - 1);
    localparam logic [3:0] PRE_LAST = 4'(WAIT_CYCLES - 2);

    state_t         state;
    logic [3:0]     cnt;
    logic           op_wr;
    logic [WAW-1:0] word_q;
    logic [31:0]    wdata_q;

    logic           req;
    logic [29:0]    idx;
    logic [WAW-1:0] word_in;
    logic           unused_idx;
    logic           buf_hit;
    logic [31:0]    buf_data;

    assign req        = rd_en | wr_en;
    assign idx        = word_index(addr, BASE_ADDR);
    assign word_in    = idx[WAW-1:0];
    assign unused_idx = ^idx[29:WAW];

    always_comb begin
        ready = 1'b0;
        if (state == ST_IDLE)
            ready = ~req;
        else if (state == ST_DONE)
            ready = 1'b1;
    end

`ifdef MEM_SRAM_RDBUF_EN
    sram_rd_buffer #(.WAW(WAW)) u_rd_buffer (
        .clk        (clk),
        .rst        (rst),
        .fill       (state == ST_HI && cnt == LAST && !op_wr),
        .fill_word  (word_q),
        .fill_data  ({sram_dq_in, rd_data[15:0]}),
        .inval      (state == ST_IDLE && wr_en),
        .inval_word (word_in),
        .look_word  (word_in),
        .hit        (buf_hit),
        .hit_data   (buf_data)
    );
`else
    assign buf_hit  = 1'b0;
    assign buf_data = '0;
`endif

    // we_n rises one cycle before each half ends so address/data outlive the strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            op_wr       <= 1'b0;
            word_q      <= '0;
            wdata_q     <= '0;
            rd_data     <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        op_wr   <= wr_en;
                        word_q  <= word_in;
                        wdata_q <= wr_data;
                        cnt     <= '0;
                        if (!wr_en && buf_hit) begin
                            state   <= ST_DONE;
                            rd_data <= buf_data;
                        end else begin
                            state       <= ST_LO;
                            sram_addr   <= {word_in, 1'b0};
                            sram_dq_out <= wr_data[15:0];
                            sram_dq_oe  <= wr_en;
                            sram_we_n   <= ~wr_en;
                        end
                    end
                end
                ST_LO: begin
                    if (cnt == LAST) begin
                        if (!op_wr)
                            rd_data[15:0] <= sram_dq_in;
                        state       <= ST_HI;
                        cnt         <= '0;
                        sram_addr   <= {word_q, 1'b1};
                        sram_dq_out <= wdata_q[31:16];
                        sram_we_n   <= ~op_wr;
                    end else begin
                        cnt <= cnt + 4'd1;
                        if (cnt == PRE_LAST)
                            sram_we_n <= 1'b1;
                    end
                end
                ST_HI: begin
                    if (cnt == LAST) begin
                        if (!op_wr)
                            rd_data[31:16] <= sram_dq_in;
                        state      <= ST_DONE;
                        cnt        <= '0;
                        sram_dq_oe <= 1'b0;
                        sram_we_n  <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                        if (cnt == PRE_LAST)
                            sram_we_n <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// tb/tb_mem_sram_ctrl.sv - randomized self-checking bench for mem_sram_ctrl against a word-level memory model
module tb_mem_sram_ctrl;

    localparam int W    = 2;
    localparam int BASE = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [31:0] addr, wr_data, rd_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n;

    logic [15:0] sram_dev [0:63];
    logic        pre_en;
    logic [5:0]  pre_a;
    logic [15:0] pre_d;

    logic [15:0] ref_mem [0:63];
    logic [31:0] last_rd;
    logic        buf_v;
    int          buf_w;

    int n_checks = 0;
    int n_fail   = 0;

    mem_sram_ctrl #(.BASE_ADDR(32'd1024), .SRAM_AW(18), .WAIT_CYCLES(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .addr        (addr),
        .wr_data     (wr_data),
        .rd_data     (rd_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_we_n   (sram_we_n)
    );

    always #5 clk = ~clk;

    // SRAM device: a strobe cut short by reset does not commit
    assign sram_dq_in = sram_dev[sram_addr[5:0]];
    always @(posedge clk) begin
        if (pre_en)
            sram_dev[pre_a] <= pre_d;
        else if (!rst && !sram_we_n)
            sram_dev[sram_addr[5:0]] <= sram_dq_out;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input int a, input logic [15:0] d);
        pre_en = 1'b1;
        pre_a  = 6'(a);
        pre_d  = d;
        ref_mem[a] = d;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    // Called at a negedge in an idle cycle; returns at the negedge of the following idle cycle.
    task automatic run_op(input logic wr, input logic rd, input int a, input logic [31:0] d,
                          input logic perturb);
        int w, exp_lat, lat;
        w       = (a - BASE) / 4;
        exp_lat = 2 * W + 1;
`ifdef MEM_SRAM_RDBUF_EN
        if (rd && !wr && buf_v && buf_w == w)
            exp_lat = 1;
`endif
        rd_en   = rd;
        wr_en   = wr;
        addr    = 32'(a);
        wr_data = d;
        #1;
        check("ready_low_on_req", {31'd0, ready}, 32'd0);
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1 && perturb) begin
                addr    = $urandom;
                wr_data = $urandom;
                rd_en   = 1'($urandom_range(0, 1));
                wr_en   = 1'($urandom_range(0, 1));
                #1;
            end
            if (ready) begin
                lat = c;
                break;
            end
        end
        check("latency", 32'(lat), 32'(exp_lat));
        if (wr) begin
            ref_mem[2*w]   = d[15:0];
            ref_mem[2*w+1] = d[31:16];
            if (buf_w == w)
                buf_v = 1'b0;
        end else if (rd) begin
            last_rd = {ref_mem[2*w+1], ref_mem[2*w]};
            buf_v   = 1'b1;
            buf_w   = w;
        end
        check("rd_data", rd_data, last_rd);
        rd_en = 1'b0;
        wr_en = 1'b0;
        @(negedge clk);
        #1;
        check("ready_idle", {31'd0, ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] rnd;
        logic [17:0] sa_before;
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; addr = '0; wr_data = '0;
        pre_en = 1'b0; pre_a = '0; pre_d = '0;
        last_rd = '0; buf_v = 1'b0; buf_w = -1;
        for (int i = 0; i < 64; i++)
            preload(i, 16'($urandom));

        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        check("rst_oe", {31'd0, sram_dq_oe}, 32'd0);
        check("rst_addr", {14'd0, sram_addr}, 32'd0);
        check("rst_dq_out", {16'd0, sram_dq_out}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // store / load / write-priority directed cases
        run_op(1'b1, 1'b0, 1024, 32'hDEAD_BEEF, 1'b0);
        check("t1_sram0", {16'd0, sram_dev[0]}, 32'h0000_BEEF);
        check("t1_sram1", {16'd0, sram_dev[1]}, 32'h0000_DEAD);
        preload(2, 16'h5678);
        preload(3, 16'h1234);
        run_op(1'b0, 1'b1, 1028, 32'h0, 1'b0);
        check("t2_rd_data", rd_data, 32'h1234_5678);
        run_op(1'b1, 1'b1, 1032, 32'h1, 1'b0);
        check("t3_sram4", {16'd0, sram_dev[4]}, 32'h0000_0001);
        check("t3_rd_kept", rd_data, 32'h1234_5678);

        // reset in the first HI cycle of a store
        preload(1, 16'hA5A5);
        rd_en = 1'b0; wr_en = 1'b1; addr = 32'd1024; wr_data = 32'hCAFE_F00D;
        for (int c = 1; c <= W + 1; c++)
            @(negedge clk);
        rst = 1'b1; wr_en = 1'b0;
        @(negedge clk);
        check("t4_we_n", {31'd0, sram_we_n}, 32'd1);
        check("t4_oe", {31'd0, sram_dq_oe}, 32'd0);
        check("t4_ready", {31'd0, ready}, 32'd1);
        check("t4_rd_data", rd_data, 32'd0);
        rst = 1'b0;
        ref_mem[0] = 16'hF00D;
        last_rd = '0; buf_v = 1'b0;
        check("t4_sram1_kept", {16'd0, sram_dev[1]}, 32'h0000_A5A5);
        check("t4_sram0", {16'd0, sram_dev[0]}, 32'h0000_F00D);
        @(negedge clk);

        // back-to-back store then load
        rnd = $urandom;
        run_op(1'b1, 1'b0, 1036, rnd, 1'b0);
        run_op(1'b0, 1'b1, 1036, 32'h0, 1'b0);
        check("t5_loopback", rd_data, rnd);

`ifdef MEM_SRAM_RDBUF_EN
        run_op(1'b0, 1'b1, 1040, 32'h0, 1'b0);
        sa_before = sram_addr;
        run_op(1'b0, 1'b1, 1040, 32'h0, 1'b0);
        check("t6_addr_quiet", {14'd0, sram_addr}, {14'd0, sa_before});
        run_op(1'b1, 1'b0, 1040, 32'h0BAD_F00D, 1'b0);
        run_op(1'b0, 1'b1, 1040, 32'h0, 1'b0);
`else
        sa_before = '0;
`endif

        for (int n = 0; n < 60; n++) begin
            int kind;
            kind = $urandom_range(0, 2);
            run_op(kind != 1, kind != 0, BASE + 4 * $urandom_range(0, 15), $urandom,
                   1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 32; i++)
            check("final_mem", {16'd0, sram_dev[i]}, {16'd0, ref_mem[i]});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
